// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (MULT/MULTU/DIV/DIVU).
// Optional MTHI/MTLO write ports are enabled by defining MD_HILO_WRITE_EN.
module md_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_md_start,
  input  logic [1:0]       i_md_op,
  input  logic [WIDTH-1:0] i_md_a,
  input  logic [WIDTH-1:0] i_md_b,
  input  logic             i_md_flush,
`ifdef MD_HILO_WRITE_EN
  input  logic             i_md_hiWe,
  input  logic             i_md_loWe,
  input  logic [WIDTH-1:0] i_md_wData,
`endif
  output logic             o_md_busy,
  output logic             o_md_done,
  output logic [WIDTH-1:0] o_md_hi,
  output logic [WIDTH-1:0] o_md_lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 b_zero_q, b_zero_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, div_shift;
  logic [WIDTH-1:0]     div_diff, div_rem, quot, rem;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod;

  // Next-state, datapath step and sign fixup
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    m_d       = m_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    neg_a     = i_md_op[0] & i_md_a[WIDTH-1];
    neg_b     = i_md_op[0] & i_md_b[WIDTH-1];
    a_abs     = neg_a ? -i_md_a : i_md_a;
    b_abs     = neg_b ? -i_md_b : i_md_b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, m_q};
    div_diff  = WIDTH'(div_shift - {1'b0, m_q});
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];

    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
    prod      = neg_res_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
`ifdef MD_HILO_WRITE_EN
        if (i_md_hiWe) hi_d = i_md_wData;
        if (i_md_loWe) lo_d = i_md_wData;
`endif
        if (i_md_start && !i_md_flush) begin
          div_d     = i_md_op[1];
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          b_zero_d  = (i_md_b == '0);
          // Multiply iterates over the multiplier, divide over the dividend
          m_d       = i_md_op[1] ? b_abs : a_abs;
          acc_d     = {WIDTH'(0), (i_md_op[1] ? a_abs : b_abs)};
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (i_md_flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
          else       acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!i_md_flush) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = neg_rem_q ? -rem : rem;
            lo_d = b_zero_q ? '1 : (neg_res_q ? -quot : quot);
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      m_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_md_busy = busy_q;
  assign o_md_done = done_q;
  assign o_md_hi   = hi_q;
  assign o_md_lo   = lo_q;

endmodule
